// File: rtl/multi_debouncer_pkg.sv
// Shared types and defaults for the N-channel debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package multi_debouncer_pkg;

    // Per-channel FSM encoding: STABLE while s2 matches the accepted level.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    localparam int   DEF_N_CH          = 4;
    localparam int   DEF_STABLE_CYCLES = 5;
    localparam int   DEF_CNT_W         = 8;
    localparam logic DEF_INIT_LEVEL    = 1'b0;
    localparam int   DEF_LONG_CYCLES   = 200;

    // Ceiling log2; clog2(v+1) is the bit count needed to hold the value v.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: 2-flop synchroniser, qualified stability counter, rise/fall pulses, optional long press.
// Latency: with tick always high, level changes STABLE_CYCLES+1 edges after s1 captures the new input.
// Backpressure: none; tick_i only gates counting. Long press built when MULTI_DEBOUNCER_LONG_PRESS_EN is defined.
module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter logic INIT_LEVEL    = DEF_INIT_LEVEL,
    parameter int   LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic pb_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > LONG_CYCLES) ? STABLE_CYCLES : LONG_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Reject configurations that cannot count to the required values.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_channel: STABLE_CYCLES must be at least 2");
    end
    if (CNT_W < clog2(MAX_CYCLES + 1)) begin : g_bad_width
        $error("debounce_channel: CNT_W too narrow for STABLE_CYCLES/LONG_CYCLES");
    end

    logic             s1_q;
    logic             s2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             accept;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser, FSM state, counter and pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q    <= INIT_LEVEL;
            s2_q    <= INIT_LEVEL;
            level_q <= INIT_LEVEL;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= pb_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Output logic: accept on the tick that completes the stable run, pulse the direction taken.
    always_comb begin
        accept  = (state_q == ST_PENDING) && tick_i && (cnt_q == CNT_LAST);
        level_d = accept ? ~level_q : level_q;
        rise_d  = accept & ~level_q;
        fall_d  = accept & level_q;
    end

    // Next state: state_q always mirrors (s2_q != level_q), so look at s1 and the next level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STABLE:  if (s1_q != level_q) state_d = ST_PENDING;
            ST_PENDING: if (s1_q == level_d) state_d = ST_STABLE;
            default:    state_d = ST_STABLE;
        endcase
    end

    // Counter: clears on acceptance or any return to STABLE, counts ticks while pending.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == ST_STABLE) || accept) begin
            cnt_d = '0;
        end else if ((state_q == ST_PENDING) && tick_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LP_TARGET = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] lp_cnt_q, lp_cnt_d;
    logic             long_q, long_d;

    // Long-press counter: runs while the accepted level is high, saturates at the target.
    always_comb begin
        lp_cnt_d = lp_cnt_q;
        long_d   = 1'b0;
        if (!level_q) begin
            lp_cnt_d = '0;
        end else if (tick_i && (lp_cnt_q != LP_TARGET)) begin
            lp_cnt_d = lp_cnt_q + 1'b1;
            long_d   = (lp_cnt_d == LP_TARGET);
        end
    end

    // Long-press registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lp_cnt_q <= '0;
            long_q   <= 1'b0;
        end else begin
            lp_cnt_q <= lp_cnt_d;
            long_q   <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer; one independent debounce_channel per input bit.
// Latency: STABLE_CYCLES+1 edges from s1 capture to db_level with sample_tick tied high.
// Backpressure: none; sample_tick qualifies samples. Long press enabled by MULTI_DEBOUNCER_LONG_PRESS_EN.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int   N_CH          = DEF_N_CH,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter logic INIT_LEVEL    = DEF_INIT_LEVEL,
    parameter int   LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic            Myclk,
    input  logic            rst_n,
    input  logic            sample_tick,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] db_rise,
    output logic [N_CH-1:0] db_fall,
    output logic [N_CH-1:0] long_press
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .INIT_LEVEL    (INIT_LEVEL),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_ch (
            .clk_i   (Myclk),
            .rst_ni  (rst_n),
            .tick_i  (sample_tick),
            .pb_i    (pb_in[gi]),
            .level_o (db_level[gi]),
            .rise_o  (db_rise[gi]),
            .fall_o  (db_fall[gi]),
            .long_o  (long_press[gi])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer (N_CH=4, STABLE_CYCLES=5, LONG_CYCLES=10).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_multi_debouncer;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       Myclk = 1'b0;
    logic       rst_n;
    logic       sample_tick;
    logic [3:0] pb_in;
    logic [3:0] db_level;
    logic [3:0] db_rise;
    logic [3:0] db_fall;
    logic [3:0] long_press;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int tick_div = 1;

    always #5 Myclk = ~Myclk;

    multi_debouncer #(
        .N_CH          (4),
        .STABLE_CYCLES (5),
        .CNT_W         (8),
        .INIT_LEVEL    (1'b0),
        .LONG_CYCLES   (10)
    ) dut (
        .Myclk       (Myclk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .pb_in       (pb_in),
        .db_level    (db_level),
        .db_rise     (db_rise),
        .db_fall     (db_fall),
        .long_press  (long_press)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n edges; sample point is 1 unit after the edge. With tick_div>1 the
    // tick is raised after edge k when k % tick_div == tick_div-1.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Myclk);
            #1;
            k++;
            if (tick_div == 1) sample_tick = 1'b1;
            else sample_tick = ((k % tick_div) == (tick_div - 1));
        end
    endtask

    logic [17:0] bounce_pat;

    initial begin
        rst_n       = 1'b0;
        pb_in       = 4'hF;
        sample_tick = 1'b1;

        // Reset: all outputs low while rst_n is low.
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_level", db_level, 4'h0);
            check("rst_rise", db_rise, 4'h0);
            check("rst_fall", db_fall, 4'h0);
            check("rst_long", long_press, 4'h0);
        end

        // Release with inputs high: s1 captures at E0, level at E6.
        rst_n = 1'b1;
        step(1);
        check("init_e0_level", db_level, 4'h0);
        step(5);
        check("init_e5_level", db_level, 4'h0);
        check("init_e5_rise", db_rise, 4'h0);
        step(1);
        check("init_e6_level", db_level, 4'hF);
        check("init_e6_rise", db_rise, 4'hF);
        check("init_e6_fall", db_fall, 4'h0);
        step(1);
        check("init_e7_rise", db_rise, 4'h0);
        check("init_e7_level", db_level, 4'hF);

        // Drop ch0 and ch1.
        pb_in = 4'hC;
        step(7);
        check("fall01_level", db_level, 4'hC);
        check("fall01_pulse", db_fall, 4'h3);
        check("fall01_rise", db_rise, 4'h0);
        step(1);
        check("fall01_clear", db_fall, 4'h0);

        // Bounce on ch0: 3 high, 2 low, 3 high, then low; never accepted.
        bounce_pat = 18'b111001110000000000;
        for (int i = 0; i < 18; i++) begin
            pb_in = {3'b110, bounce_pat[17-i]};
            step(1);
            check("bounce_rise", db_rise, 4'h0);
            check("bounce_level", db_level, 4'hC);
        end

        // ch2 falls with a tick every 4th cycle: ticks land on E4,E8,...,E20.
        tick_div    = 4;
        k           = -1;
        sample_tick = 1'b0;
        pb_in       = 4'h8;
        step(20);
        check("tick_e19_level", db_level, 4'hC);
        check("tick_e19_fall", db_fall, 4'h0);
        step(1);
        check("tick_e20_level", db_level, 4'h8);
        check("tick_e20_fall", db_fall, 4'h4);
        check("tick_e20_rise", db_rise, 4'h0);
        step(1);
        check("tick_e21_fall", db_fall, 4'h0);
        check("tick_e21_level", db_level, 4'h8);

        // Simultaneous ch1 rise and ch3 fall.
        tick_div    = 1;
        sample_tick = 1'b1;
        pb_in       = 4'h2;
        step(6);
        check("simul_e5_level", db_level, 4'h8);
        step(1);
        check("simul_rise", db_rise, 4'h2);
        check("simul_fall", db_fall, 4'h8);
        check("simul_level", db_level, 4'h2);
        step(1);
        check("simul_rise_clr", db_rise, 4'h0);
        check("simul_fall_clr", db_fall, 4'h0);

        // Reset mid-count on ch0: counter at 4, reset discards it.
        pb_in = 4'h3;
        step(6);
        check("mid_pre_level", db_level, 4'h2);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_level", db_level, 4'h0);
        check("mid_rst_rise", db_rise, 4'h0);
        check("mid_rst_long", long_press, 4'h0);
        rst_n = 1'b1;
        step(6);
        check("mid_e5_level", db_level, 4'h0);
        step(1);
        check("mid_e6_level", db_level, 4'h3);
        check("mid_e6_rise", db_rise, 4'h3);

        // Hold high: single long-press pulse 10 cycles after db_rise (when enabled).
        for (int i = 1; i <= 30; i++) begin
            step(1);
            check("long_press", long_press, (LP_EN && i == 10) ? 4'h3 : 4'h0);
        end
        check("long_level", db_level, 4'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
